zircon_avalon_ir_ctrl: RTL and testbench
========================================

# zircon_avalon_ir_ctrl

Avalon-MM controller that sequences the infrared decoder's output toward the Nios II. It captures each decoded 8-bit key code, optionally suppresses auto-repeat codes inside a programmable hold-off window, and buffers codes in a FIFO. It raises a level interrupt while codes are pending and lets software pop codes, read status, and configure capture. It sits between the IR decode logic and the system interconnect, replacing direct register exposure of the last decoded byte.

## Interface
- FIFO_DEPTH, 8: code FIFO depth; a power of two, 2..64.
- TICK_DIV, 50000: csi_clk cycles per hold-off tick (1 ms at 50 MHz).
- csi_clk  in  1  system clock; the only clock.
- rsi_reset_n  in  1  reset; asynchronous, active-low.
- avs_address  in  2  register select.
- avs_read  in  1  read strobe, one cycle per access.
- avs_write  in  1  write strobe, one cycle per access.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data; registered, read latency 1.
- ins_irq  out  1  level interrupt.
- ir_valid  in  1  one-cycle pulse from the decoder, synchronous to csi_clk.
- ir_code  in  8  decoded key code; valid when ir_valid=1.

## Operation
- Registers:
  - 0 DATA (R): {23'b0, valid, code[7:0]}. A read pops the FIFO head. When the FIFO is empty, the read returns 0 and nothing changes.
  - 1 STATUS (R): bit0 empty, bit1 irq pending, bit2 overflow, bits[7+W:8] count, where W = log2(FIFO_DEPTH)+1. STATUS (W): writing 1 to bit2 clears overflow.
  - 2 CTRL (R/W): bit0 capture_en, bit1 irq_en, bit2 filter_en. Bit3 is flush: write-only and self-clearing. Flush empties the FIFO, clears overflow and clears the filter window. Bit3 always reads 0.
  - 3 HOLDOFF (R/W): bits[7:0] hold-off window in ticks.
  - Writes to DATA are ignored. Unused read bits return 0.
- Capture rules:
  - ir_valid with capture_en=0 is ignored.
  - Tick counter: free-running, 0..TICK_DIV-1, emits a tick on wrap.
  - Window counter: 8 bits. It decrements on each tick while nonzero. The window is active while the counter is nonzero.
  - Repeat: ir_valid with filter_en=1, window active and ir_code equal to last_code. The code is dropped and the window reloads to HOLDOFF.
  - Otherwise the code is pushed, last_code is set to ir_code, and the window loads HOLDOFF.
  - HOLDOFF=0 disables suppression.
- FIFO behaviour:
  - Push while full drops the new code and sets overflow (sticky). FIFO contents are unchanged.
  - Push and pop in the same cycle: both occur and count is unchanged. When the FIFO is full, the pop frees the slot, so the push succeeds.
  - Push and pop in the same cycle on an empty FIFO: the read returns 0, and the pushed code is stored.
  - Flush coincident with ir_valid: flush wins and the code is discarded.
  - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Interrupt: irq pending = ~empty. ins_irq = irq_en & ~empty. Software clears it by draining the FIFO.
- Reset values: FIFO empty, count 0, overflow 0, CTRL=0x1, HOLDOFF=0xC8, last_code=0x00, window 0, tick 0, avs_readdata=0, ins_irq=0.
- Reset mid-operation discards all buffered codes immediately (asynchronous).

## Timing
- ir_valid sampled at edge N: the code is in the FIFO and count/status are updated from N+1.
- ins_irq is combinational from registered state and asserts from N+1.
- avs_read at edge R: avs_readdata valid after R, held until the next read. The pop and count decrement take effect after R.
- ins_irq deasserts after R when the last code is popped.
- avs_write at edge W: the register updates after W. Flush completes in that same edge.
- A new HOLDOFF value applies to the next window load only.
- Window reload takes priority over a tick decrement in the same cycle.
- Back-to-back reads every cycle pop one code per cycle.

## Test plan
- Reset, then read all registers: STATUS=0x1, CTRL=0x1, HOLDOFF=0xC8, DATA=0, ins_irq=0.
- Write CTRL=0x3. Pulse ir_valid with codes 0x45 then 0x46. Expected: STATUS count=2 and ins_irq=1. DATA reads return 0x145, then 0x146, then 0. ins_irq=0 after the second pop.
- Depth check: push 9 codes 0x10..0x18 with DEPTH=8. Expected: overflow=1, count=8, pops return 0x10..0x17. Writing STATUS=0x4 clears overflow.
- Filter: CTRL=0x5, TICK_DIV=4, HOLDOFF=3. Apply 0x20, then 0x20 after 8 cycles. The second is dropped.
- Filter, continued: apply 0x20 again 13+ cycles after the last reload. It is accepted. A code of 0x21 inside the window is accepted.
- With FIFO full, a pop and an ir_valid of 0x77 in the same cycle leave count=8, with 0x77 last out.
- Flush coincident with ir_valid: count=0 and empty.
- Reset asserted with 3 codes queued: count=0 and ins_irq=0 immediately. After release, CTRL=0x1.

Source files
------------

// File: rtl/zircon_avalon_ir_ctrl.sv
// Avalon-MM front end for the IR decoder: captures key codes, filters auto-repeat
// inside a tick-based hold-off window, and queues codes in a FIFO for software.
module zircon_avalon_ir_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TICK_DIV   = 50000
) (
  input  logic        csi_clk,
  input  logic        rsi_reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        ins_irq,
  input  logic        ir_valid,
  input  logic [7:0]  ir_code
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TickMax = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CountFull = CW'(FIFO_DEPTH);

  localparam logic [1:0] AddrData    = 2'd0;
  localparam logic [1:0] AddrStatus  = 2'd1;
  localparam logic [1:0] AddrCtrl    = 2'd2;
  localparam logic [1:0] AddrHoldoff = 2'd3;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [7:0]    holdoff_q, holdoff_d;
  logic [7:0]    last_code_q, last_code_d;
  logic [7:0]    window_q, window_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [31:0]   readdata_q, readdata_d;

  logic empty, full, tick, wr_ctrl, wr_status, flush;
  logic capture, is_repeat, push_req, push, pop;
  logic unused_wdata;

  assign unused_wdata = ^avs_writedata[31:8];

  assign empty     = (count_q == '0);
  assign full      = (count_q == CountFull);
  assign tick      = (tick_q == TickMax);
  assign wr_ctrl   = avs_write && (avs_address == AddrCtrl);
  assign wr_status = avs_write && (avs_address == AddrStatus);
  assign flush     = wr_ctrl && avs_writedata[3];

  // Flush discards a coincident code, so it gates capture entirely.
  assign capture   = ir_valid && ctrl_q[0] && !flush;
  assign is_repeat = ctrl_q[2] && (window_q != 8'd0) && (ir_code == last_code_q);
  assign push_req  = capture && !is_repeat;
  assign pop       = avs_read && (avs_address == AddrData) && !empty && !flush;
  // A same-cycle pop frees a slot in a full FIFO.
  assign push      = push_req && (!full || pop);

  assign ins_irq      = ctrl_q[1] && !empty;
  assign avs_readdata = readdata_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    ctrl_d      = ctrl_q;
    holdoff_d   = holdoff_q;
    last_code_d = last_code_q;
    window_d    = window_q;
    tick_d      = tick ? '0 : tick_q + TW'(1);
    readdata_d  = readdata_q;

    if (push) begin
      wr_ptr_d    = wr_ptr_q + AW'(1);
      last_code_d = ir_code;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (wr_status && avs_writedata[2]) overflow_d = 1'b0;
    if (push_req && full && !pop) overflow_d = 1'b1;

    // Any accepted or suppressed capture reloads the window ahead of a tick decrement.
    if (capture) window_d = holdoff_q;
    else if (tick && window_q != 8'd0) window_d = window_q - 8'd1;

    if (wr_ctrl) ctrl_d = avs_writedata[2:0];
    if (avs_write && avs_address == AddrHoldoff) holdoff_d = avs_writedata[7:0];

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      window_d   = 8'd0;
    end

    if (avs_read) begin
      readdata_d = 32'd0;
      case (avs_address)
        AddrData:    if (!empty) readdata_d = {23'd0, 1'b1, mem_q[rd_ptr_q]};
        AddrStatus:  readdata_d = {{(24 - CW){1'b0}}, count_q, 5'd0, overflow_q, !empty, empty};
        AddrCtrl:    readdata_d = {29'd0, ctrl_q};
        AddrHoldoff: readdata_d = {24'd0, holdoff_q};
        default:     readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      ctrl_q      <= 3'b001;
      holdoff_q   <= 8'hC8;
      last_code_q <= 8'h00;
      window_q    <= 8'd0;
      tick_q      <= '0;
      readdata_q  <= 32'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      ctrl_q      <= ctrl_d;
      holdoff_q   <= holdoff_d;
      last_code_q <= last_code_d;
      window_q    <= window_d;
      tick_q      <= tick_d;
      readdata_q  <= readdata_d;
    end
  end

  // Storage needs no reset; count and pointers define what is valid.
  always_ff @(posedge csi_clk) begin
    if (push) mem_q[wr_ptr_q] <= ir_code;
  end

endmodule

// File: tb/tb_zircon_avalon_ir_ctrl.sv
// Directed bench for zircon_avalon_ir_ctrl: FIFO, filter, flush and reset scenarios.
module tb_zircon_avalon_ir_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;
  logic        ir_valid = 1'b0;
  logic [7:0]  ir_code = 8'd0;

  int checks = 0;
  int errors = 0;

  zircon_avalon_ir_ctrl #(
    .FIFO_DEPTH(8),
    .TICK_DIV  (4)
  ) dut (
    .csi_clk      (clk),
    .rsi_reset_n  (rst_n),
    .avs_address  (address),
    .avs_read     (rd),
    .avs_write    (wr),
    .avs_writedata(wdata),
    .avs_readdata (rdata),
    .ins_irq      (irq),
    .ir_valid     (ir_valid),
    .ir_code      (ir_code)
  );

  always #5 clk = ~clk;

  // All helpers start just after a rising edge and return 1 ns after the next one.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic ir_pulse(input logic [7:0] c);
    ir_code = c; ir_valid = 1'b1;
    @(posedge clk); #1;
    ir_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b want 0", irq); end
    bus_read(2'd1, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_status got %h want 00000001", d); end
    bus_read(2'd2, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_ctrl got %h want 00000001", d); end
    bus_read(2'd3, d);
    checks++; if (d !== 32'hC8) begin errors++; $display("FAIL reset_holdoff got %h want 000000c8", d); end
    bus_read(2'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    bus_write(2'd2, 32'h3);
    ir_pulse(8'h45);
    ir_pulse(8'h46);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq_set got %0b want 1", irq); end
    bus_read(2'd1, d);
    checks++; if (d !== 32'h202) begin errors++; $display("FAIL basic_status got %h want 00000202", d); end
    bus_read(2'd0, d);
    checks++; if (d !== 32'h145) begin errors++; $display("FAIL basic_pop1 got %h want 00000145", d); end
    bus_read(2'd0, d);
    checks++; if (d !== 32'h146) begin errors++; $display("FAIL basic_pop2 got %h want 00000146", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_clear got %0b want 0", irq); end
    bus_read(2'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_pop_empty got %h want 00000000", d); end
  endtask

  task automatic test_depth();
    logic [31:0] d;
    for (int i = 0; i < 9; i++) ir_pulse(8'h10 + 8'(i));
    bus_read(2'd1, d);
    checks++; if (d !== 32'h806) begin errors++; $display("FAIL depth_status got %h want 00000806", d); end
    for (int i = 0; i < 8; i++) begin
      bus_read(2'd0, d);
      checks++;
      if (d !== 32'h110 + 32'(i)) begin
        errors++; $display("FAIL depth_pop%0d got %h want %h", i, d, 32'h110 + 32'(i));
      end
    end
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL depth_ovf_clear got %h want 00000001", d); end
  endtask

  task automatic test_filter();
    logic [31:0] d;
    bus_write(2'd3, 32'h3);
    bus_write(2'd2, 32'h5);
    ir_pulse(8'h20);
    repeat (7) @(posedge clk);
    #1;
    ir_pulse(8'h20);          // 8 cycles later: window still open, dropped
    repeat (13) @(posedge clk);
    #1;
    ir_pulse(8'h20);          // window has expired
    ir_pulse(8'h21);          // different code inside window
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL filter_irq_masked got %0b want 0", irq); end
    bus_read(2'd1, d);
    checks++; if (d !== 32'h302) begin errors++; $display("FAIL filter_status got %h want 00000302", d); end
    bus_read(2'd0, d);
    checks++; if (d !== 32'h120) begin errors++; $display("FAIL filter_pop1 got %h want 00000120", d); end
    bus_read(2'd0, d);
    checks++; if (d !== 32'h120) begin errors++; $display("FAIL filter_pop2 got %h want 00000120", d); end
    bus_read(2'd0, d);
    checks++; if (d !== 32'h121) begin errors++; $display("FAIL filter_pop3 got %h want 00000121", d); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    bus_write(2'd2, 32'hB);   // flush, capture, irq, no filter
    for (int i = 0; i < 8; i++) ir_pulse(8'h30 + 8'(i));
    address = 2'd0; rd = 1'b1; ir_code = 8'h77; ir_valid = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0; ir_valid = 1'b0;
    checks++; if (rdata !== 32'h130) begin errors++; $display("FAIL full_pop_data got %h want 00000130", rdata); end
    bus_read(2'd1, d);
    checks++; if (d !== 32'h802) begin errors++; $display("FAIL full_pushpop_status got %h want 00000802", d); end
    for (int i = 0; i < 8; i++) bus_read(2'd0, d);
    checks++; if (d !== 32'h177) begin errors++; $display("FAIL full_last_out got %h want 00000177", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL full_drained_irq got %0b want 0", irq); end
  endtask

  task automatic test_flush_vs_capture();
    logic [31:0] d;
    ir_pulse(8'h50);
    ir_pulse(8'h51);
    address = 2'd2; wdata = 32'hB; wr = 1'b1; ir_code = 8'h52; ir_valid = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; ir_valid = 1'b0;
    bus_read(2'd1, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL flush_status got %h want 00000001", d); end
    bus_read(2'd2, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL flush_ctrl_readback got %h want 00000003", d); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    ir_pulse(8'h61);
    ir_pulse(8'h62);
    ir_pulse(8'h63);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rst_pre_irq got %0b want 1", irq); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_async_irq got %0b want 0", irq); end
    checks++; if (dut.count_q !== 4'd0) begin errors++; $display("FAIL rst_async_count got %0d want 0", dut.count_q); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_read(2'd2, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rst_ctrl got %h want 00000001", d); end
    bus_read(2'd1, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rst_status got %h want 00000001", d); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_depth();
    test_filter();
    test_full_push_pop();
    test_flush_vs_capture();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
